// File: rtl/mips_single_cycle_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_single_cycle_top : single-cycle MIPS-subset CPU (fetch..commit in 1 clk)|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] RegData [0:31] = '{default: 32'h0};

  // Register contents survive reset; reset only blocks the write port.
  always_ff @(posedge clk) begin
    if (!rst && i_we && (i_wa != 5'd0)) begin
      RegData[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? 32'h0 : RegData[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? 32'h0 : RegData[i_ra2];
endmodule

module mips_data_memory (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [2:0]  i_widx,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);
  logic [7:0] Dmem [0:31] = '{default: 8'h0};

  always_ff @(posedge clk) begin
    if (!rst && i_we) begin
      Dmem[{i_widx, 2'b00}] <= i_wdata[7:0];
      Dmem[{i_widx, 2'b01}] <= i_wdata[15:8];
      Dmem[{i_widx, 2'b10}] <= i_wdata[23:16];
      Dmem[{i_widx, 2'b11}] <= i_wdata[31:24];
    end
  end

  assign o_rdata = {Dmem[{i_widx, 2'b11}], Dmem[{i_widx, 2'b10}],
                    Dmem[{i_widx, 2'b01}], Dmem[{i_widx, 2'b00}]};
endmodule

module mips_single_cycle_top #(
  parameter int    IMEM_WORDS = 64,
  parameter string IMEM_FILE  = "instructions.mem"
) (
  input  logic clk,
  input  logic reset
);
  localparam int   c_IDX_W     = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam logic c_HAS_IMAGE = (IMEM_FILE != "");

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_J     = 6'h02;

  localparam logic [3:0] c_ALU_ADD = 4'b0010;
  localparam logic [3:0] c_ALU_SUB = 4'b0110;
  localparam logic [3:0] c_ALU_AND = 4'b0000;
  localparam logic [3:0] c_ALU_OR  = 4'b0001;
  localparam logic [3:0] c_ALU_SLT = 4'b0111;

  // Built-in Fibonacci image: $s0 = n, leaves F(n) in $s1 and in data word 0.
  logic [31:0] imem [0:IMEM_WORDS-1] = '{
    0: 32'h2010000A, 1: 32'h20080000, 2: 32'h20090001, 3: 32'h200A0000,
    4: 32'h11500005, 5: 32'h01095820, 6: 32'h01204020, 7: 32'h01604820,
    8: 32'h214A0001, 9: 32'h08000004, 10: 32'h01008820, 11: 32'hAC110000,
    12: 32'h0800000C, default: 32'h0};

  logic [31:0]        pc_in;
  logic [31:0]        im_instruction;
  logic [1:0]         c_ALUOp;
  logic [3:0]         c_ALUcontrol;
  logic               c_MemRead;
  logic               c_MemWrite;
  logic [31:0]        r_read1;
  logic [31:0]        r_read2;
  logic [31:0]        alu_result;
  logic [31:0]        r_wbdata;

  logic [c_IDX_W-1:0] w_imem_idx;
  logic [5:0]         w_op;
  logic [5:0]         w_funct;
  logic [31:0]        w_imm_sext;
  logic               w_funct_ok;
  logic               w_reg_dst;
  logic               w_alu_src;
  logic               w_reg_write;
  logic               w_branch;
  logic               w_jump;
  logic [31:0]        w_alu_b;
  logic               w_zero;
  logic [31:0]        w_mem_rdata;
  logic [4:0]         w_wreg;
  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_branch_target;
  logic [31:0]        w_pc_next;

  assign w_imem_idx     = c_IDX_W'(32'(pc_in[7:2]) % IMEM_WORDS);
  assign im_instruction = c_HAS_IMAGE ? imem[w_imem_idx] : 32'h0;

  assign w_op       = im_instruction[31:26];
  assign w_funct    = im_instruction[5:0];
  assign w_imm_sext = {{16{im_instruction[15]}}, im_instruction[15:0]};

  always_comb begin
    w_funct_ok = 1'b0;
    case (w_funct)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: w_funct_ok = 1'b1;
      default:                           w_funct_ok = 1'b0;
    endcase
  end

  // Unknown opcodes and unknown R-type functs fall through as NOPs.
  always_comb begin
    w_reg_dst   = 1'b0;
    w_alu_src   = 1'b0;
    w_reg_write = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    c_MemRead   = 1'b0;
    c_MemWrite  = 1'b0;
    c_ALUOp     = 2'b00;
    case (w_op)
      c_OP_RTYPE: begin
        w_reg_dst   = 1'b1;
        w_reg_write = w_funct_ok;
        c_ALUOp     = 2'b10;
      end
      c_OP_ADDI: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      c_OP_LW: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        c_MemRead   = 1'b1;
      end
      c_OP_SW: begin
        w_alu_src  = 1'b1;
        c_MemWrite = 1'b1;
      end
      c_OP_BEQ: begin
        w_branch = 1'b1;
        c_ALUOp  = 2'b01;
      end
      c_OP_J:  w_jump = 1'b1;
      default: w_jump = 1'b0;
    endcase
  end

  always_comb begin
    c_ALUcontrol = c_ALU_ADD;
    case (c_ALUOp)
      2'b00: c_ALUcontrol = c_ALU_ADD;
      2'b01: c_ALUcontrol = c_ALU_SUB;
      2'b10: begin
        case (w_funct)
          6'h22:   c_ALUcontrol = c_ALU_SUB;
          6'h24:   c_ALUcontrol = c_ALU_AND;
          6'h25:   c_ALUcontrol = c_ALU_OR;
          6'h2A:   c_ALUcontrol = c_ALU_SLT;
          default: c_ALUcontrol = c_ALU_ADD;
        endcase
      end
      default: c_ALUcontrol = c_ALU_ADD;
    endcase
  end

  mips_regfile u_Register (
    .clk   (clk),
    .rst   (reset),
    .i_we  (w_reg_write),
    .i_ra1 (im_instruction[25:21]),
    .i_ra2 (im_instruction[20:16]),
    .i_wa  (w_wreg),
    .i_wd  (r_wbdata),
    .o_rd1 (r_read1),
    .o_rd2 (r_read2)
  );

  assign w_alu_b = w_alu_src ? w_imm_sext : r_read2;

  always_comb begin
    alu_result = 32'h0;
    case (c_ALUcontrol)
      c_ALU_ADD: alu_result = r_read1 + w_alu_b;
      c_ALU_SUB: alu_result = r_read1 - w_alu_b;
      c_ALU_AND: alu_result = r_read1 & w_alu_b;
      c_ALU_OR:  alu_result = r_read1 | w_alu_b;
      c_ALU_SLT: alu_result = {31'h0, ($signed(r_read1) < $signed(w_alu_b))};
      default:   alu_result = 32'h0;
    endcase
  end

  assign w_zero = (alu_result == 32'h0);

  mips_data_memory u_Data_memory (
    .clk     (clk),
    .rst     (reset),
    .i_we    (c_MemWrite),
    .i_widx  (alu_result[4:2]),
    .i_wdata (r_read2),
    .o_rdata (w_mem_rdata)
  );

  assign r_wbdata = c_MemRead ? w_mem_rdata : alu_result;
  assign w_wreg   = w_reg_dst ? im_instruction[15:11] : im_instruction[20:16];

  assign w_pc_plus4      = pc_in + 32'd4;
  assign w_branch_target = w_pc_plus4 + {w_imm_sext[29:0], 2'b00};

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_jump) begin
      w_pc_next = {w_pc_plus4[31:28], im_instruction[25:0], 2'b00};
    end else if (w_branch && w_zero) begin
      w_pc_next = w_branch_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_in <= 32'h0;
    end else begin
      pc_in <= w_pc_next;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mips_single_cycle_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mips_single_cycle_top : scoreboard bench for the single-cycle MIPS core  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mips_single_cycle_top;
  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  localparam int P_PC = 0, P_ALUOP = 1, P_ACTRL = 2, P_MRD = 3, P_MWR = 4;
  localparam int P_REG = 5, P_BYTE = 6, P_WORD = 7, P_ALU = 8, P_WB = 9;

  typedef struct {
    int          at;
    int          sel;
    int          idx;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];

  mips_single_cycle_top #(.IMEM_WORDS(64), .IMEM_FILE("instructions.mem")) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(input int sel, input int idx);
    logic [4:0] k;
    k = 5'(idx);
    case (sel)
      P_PC:    return dut.pc_in;
      P_ALUOP: return {30'h0, dut.c_ALUOp};
      P_ACTRL: return {28'h0, dut.c_ALUcontrol};
      P_MRD:   return {31'h0, dut.c_MemRead};
      P_MWR:   return {31'h0, dut.c_MemWrite};
      P_REG:   return dut.u_Register.RegData[k];
      P_BYTE:  return {24'h0, dut.u_Data_memory.Dmem[k]};
      P_WORD:  return {dut.u_Data_memory.Dmem[k + 5'd3], dut.u_Data_memory.Dmem[k + 5'd2],
                       dut.u_Data_memory.Dmem[k + 5'd1], dut.u_Data_memory.Dmem[k]};
      P_ALU:   return dut.alu_result;
      P_WB:    return dut.r_wbdata;
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  // Monitor: resolves every expectation that is due in the current cycle.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() != 0 && sbq[0].at <= cyc) begin
      e   = sbq.pop_front();
      act = probe(e.sel, e.idx);
      checks = checks + 1;
      if (act !== e.exp) begin
        errors = errors + 1;
        $display("FAIL %s: actual %h required %h (cycle %0d)", e.name, act, e.exp, cyc);
      end
    end
  end

  task automatic expect_val(input int sel, input int idx, input logic [31:0] exp,
                            input string name);
    exp_t e;
    e.at = cyc; e.sel = sel; e.idx = idx; e.exp = exp; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_ins(input int target);
    return {6'h02, 26'(target)};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) dut.imem[i] = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    step(2);
    expect_val(P_PC, 0, 32'h0, "reset_pc");
    expect_val(P_REG, 16, 32'h0, "reset_reg16_zero");

    // Built-in Fibonacci image, n = 10.
    reset = 1'b0;
    step(85);
    expect_val(P_REG, 16, 32'd10, "fib_s0");
    expect_val(P_REG, 17, 32'h37, "fib_s1");
    expect_val(P_WORD, 0, 32'h37, "fib_dmem0");
    expect_val(P_PC, 0, 32'h30, "fib_halt_pc");

    // Program A: ALU ops, $zero, undefined opcode, store/load.
    reset = 1'b1;
    clear_rom();
    dut.imem[0]  = i_ins(8, 0, 8, 5);
    dut.imem[1]  = i_ins(8, 0, 8, 7);
    dut.imem[2]  = i_ins(8, 0, 9, 3);
    dut.imem[3]  = r_ins(8, 9, 10, 'h20);
    dut.imem[4]  = r_ins(8, 9, 10, 'h22);
    dut.imem[5]  = r_ins(8, 9, 10, 'h24);
    dut.imem[6]  = r_ins(8, 9, 10, 'h25);
    dut.imem[7]  = r_ins(9, 8, 10, 'h2A);
    dut.imem[8]  = i_ins(8, 0, 0, 9);
    dut.imem[9]  = 32'hFC0A1234;
    dut.imem[10] = i_ins(8, 0, 8, 'hDEAE);
    for (int i = 11; i < 27; i++) dut.imem[i] = r_ins(8, 8, 8, 'h20);
    dut.imem[27] = i_ins(8, 8, 8, 'hBEEF);
    dut.imem[28] = i_ins('h2B, 0, 8, 4);
    dut.imem[29] = i_ins('h23, 0, 9, 4);
    dut.imem[30] = j_ins(30);
    step(1);
    expect_val(P_PC, 0, 32'h0, "rst_pc_progA");
    reset = 1'b0;
    #1;
    expect_val(P_ALUOP, 0, 32'h0, "addi_aluop");
    step(1);
    expect_val(P_REG, 8, 32'h5, "addi_t0");
    expect_val(P_PC, 0, 32'h4, "addi_pc");
    step(2);
    expect_val(P_ACTRL, 0, 32'h2, "add_ctrl");
    expect_val(P_ALUOP, 0, 32'h2, "rtype_aluop");
    step(1);
    expect_val(P_REG, 10, 32'hA, "add_res");
    expect_val(P_ACTRL, 0, 32'h6, "sub_ctrl");
    step(1);
    expect_val(P_REG, 10, 32'h4, "sub_res");
    expect_val(P_ACTRL, 0, 32'h0, "and_ctrl");
    step(1);
    expect_val(P_REG, 10, 32'h3, "and_res");
    expect_val(P_ACTRL, 0, 32'h1, "or_ctrl");
    step(1);
    expect_val(P_REG, 10, 32'h7, "or_res");
    expect_val(P_ACTRL, 0, 32'h7, "slt_ctrl");
    step(1);
    expect_val(P_REG, 10, 32'h1, "slt_res");
    step(1);
    expect_val(P_REG, 0, 32'h0, "zero_reg");
    expect_val(P_PC, 0, 32'h24, "zero_pc");
    expect_val(P_MWR, 0, 32'h0, "undef_memwrite");
    step(1);
    expect_val(P_PC, 0, 32'h28, "undef_pc");
    expect_val(P_REG, 10, 32'h1, "undef_no_write");
    step(18);
    expect_val(P_REG, 8, 32'hDEADBEEF, "build_t0");
    expect_val(P_MWR, 0, 32'h1, "sw_memwrite");
    expect_val(P_MRD, 0, 32'h0, "sw_memread");
    step(1);
    expect_val(P_WORD, 4, 32'hDEADBEEF, "sw_word");
    expect_val(P_BYTE, 4, 32'hEF, "sw_byte4");
    expect_val(P_BYTE, 7, 32'hDE, "sw_byte7");
    expect_val(P_MRD, 0, 32'h1, "lw_memread");
    expect_val(P_MWR, 0, 32'h0, "lw_memwrite");
    expect_val(P_WB, 0, 32'hDEADBEEF, "lw_wbdata");
    step(1);
    expect_val(P_REG, 9, 32'hDEADBEEF, "lw_t1");
    expect_val(P_MRD, 0, 32'h0, "j_memread");

    // Program B: branches, jump, mid-program reset.
    reset = 1'b1;
    clear_rom();
    dut.imem[0] = i_ins(8, 0, 8, 1);
    dut.imem[1] = i_ins(8, 0, 9, 2);
    dut.imem[4] = i_ins(4, 8, 8, 2);
    dut.imem[7] = j_ins(8);
    dut.imem[8] = j_ins(8);
    step(1);
    reset = 1'b0;
    step(4);
    expect_val(P_PC, 0, 32'h10, "beq_at_pc");
    expect_val(P_ALUOP, 0, 32'h1, "beq_aluop");
    step(1);
    expect_val(P_PC, 0, 32'h1C, "beq_taken");
    step(1);
    expect_val(P_PC, 0, 32'h20, "j_target");
    reset = 1'b1;
    step(1);
    expect_val(P_PC, 0, 32'h0, "midreset_pc");
    expect_val(P_REG, 8, 32'h1, "midreset_reg_kept");
    expect_val(P_WORD, 4, 32'hDEADBEEF, "midreset_mem_kept");
    dut.imem[4] = i_ins(4, 8, 9, 2);
    reset = 1'b0;
    step(5);
    expect_val(P_PC, 0, 32'h14, "beq_not_taken");

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: actual %0d pending required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
